// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM-state enums plus
// the helper that separates single-cycle ops from the iterative mul/div ops.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIVU = 4'd11,
        ALU_REMU = 4'd12
    } alu_op_e;  // 13..15 are illegal and deliberately left unnamed

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic alu_is_multicycle(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply / divide / remainder unit.
// One DATA_W-bit accumulator is shared: it collects partial products for MUL
// and holds the running remainder for DIVU/REMU.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   start       load a/b/op and begin DATA_W iterations
//   op          ALU_MUL, ALU_DIVU or ALU_REMU
//   a, b        operands (b is the multiplicand or the divisor)
//   busy        iterations in progress
//   done        one-cycle pulse; result is valid while done is high
//   result      product low half, quotient or remainder
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] acc;   // partial product / running remainder
    logic [DATA_W-1:0] q;     // multiplier (shifts right) / dividend->quotient (shifts left)
    logic [DATA_W-1:0] m;     // multiplicand (shifts left) / divisor (constant)
    logic [CNT_W-1:0]  cnt;
    alu_op_e           op_q;

    // Restoring-division trial: shift the next dividend bit into the remainder
    // and try subtracting the divisor; bit DATA_W of diff is the borrow.
    // With a zero divisor no borrow ever occurs, so the quotient fills with
    // ones and the remainder ends equal to the dividend -- exactly the
    // required divide-by-zero results, with no special case.
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] diff;
    assign rem_sh = {acc, q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, m};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            q    <= '0;
            m    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            op_q <= ALU_ADD;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= '0;
                q    <= a;
                m    <= b;
                cnt  <= '0;
                busy <= 1'b1;
                op_q <= op;
            end else if (busy) begin
                if (op_q == ALU_MUL) begin
                    if (q[0]) acc <= acc + m;
                    m <= m << 1;
                    q <= q >> 1;
                end else if (!diff[DATA_W]) begin
                    acc <= diff[DATA_W-1:0];
                    q   <= {q[DATA_W-2:0], 1'b1};
                end else begin
                    acc <= rem_sh[DATA_W-1:0];
                    q   <= {q[DATA_W-2:0], 1'b0};
                end
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign result = (op_q == ALU_DIVU) ? q : acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I-style ALU with iterative unsigned mul/div/rem.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   in_valid/in_ready      operand channel (alu_op, src1, src2)
//   out_valid/out_ready    result channel (alu_result, zero, err)
//   alu_result             registered result, held until output transfer
//   zero                   alu_result == 0
//   err                    an illegal opcode (13..15) was accepted
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              err
);

    localparam int SH_W = $clog2(DATA_W);

    alu_state_e        state_q, state_d;
    alu_op_e           op_e;
    logic              op_multi;
    logic              in_fire;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] sc_result;
    logic              sc_err;
    logic              md_busy, md_done;
    logic [DATA_W-1:0] md_result;

    assign op_e     = alu_op_e'(alu_op[3:0]);
    assign op_multi = alu_is_multicycle(op_e);
    assign shamt    = src2[SH_W-1:0];
    assign in_fire  = in_valid && in_ready;

    // Single-cycle datapath.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sc_result = '0;
        sc_err    = 1'b0;
        case (op_e)
            ALU_ADD:  sc_result = src1 + src2;
            ALU_SUB:  sc_result = src1 - src2;
            ALU_SLL:  sc_result = src1 << shamt;
            ALU_SLT:  sc_result = {{(DATA_W-1){1'b0}}, $signed(src1) < $signed(src2)};
            ALU_XOR:  sc_result = src1 ^ src2;
            ALU_SRL:  sc_result = src1 >> shamt;
            ALU_OR:   sc_result = src1 | src2;
            ALU_AND:  sc_result = src1 & src2;
            ALU_SLTU: sc_result = {{(DATA_W-1){1'b0}}, src1 < src2};
            ALU_SRA:  sc_result = DATA_W'($signed(src1) >>> shamt);
            ALU_MUL, ALU_DIVU, ALU_REMU: sc_result = '0;  // handled by alu_muldiv
            default:  sc_err    = 1'b1;
        endcase
    end

    alu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (in_fire && op_multi && !md_busy),
        .op     (op_e),
        .a      (src1),
        .b      (src2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // In DONE, in_ready mirrors out_ready: a new op may only enter in the
    // same cycle the held result leaves, which gives back-to-back issue.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = op_multi ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (md_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_d = op_multi ? ST_BUSY : ST_DONE;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers only load on an accepted single-cycle op or on mul/div
    // completion, so they stay frozen throughout DONE until the output leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result <= '0;
            zero       <= 1'b1;
            err        <= 1'b0;
        end else if (in_fire && !op_multi) begin
            alu_result <= sc_result;
            zero       <= (sc_result == '0);
            err        <= sc_err;
        end else if ((state_q == ST_BUSY) && md_done) begin
            alu_result <= md_result;
            zero       <= (md_result == '0);
            err        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops scored
// against a plain-arithmetic reference model.
module tb_alu_seq;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int MC_LAT = DATA_W + 1;  // edges from accept to out_valid for mul/div

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   alu_op = '0;
    logic [DATA_W-1:0] src1 = '0;
    logic [DATA_W-1:0] src2 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic              err;

    int n_checks = 0;
    int n_fails  = 0;

    alu_seq #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .src1       (src1),
        .src2       (src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model written straight from the opcode table.
    task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic e, output int lat);
        logic [4:0] sh;
        sh  = b[4:0];
        e   = 1'b0;
        lat = 0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  r = a ^ b;
            4'd5:  r = a >> sh;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  r = 32'($signed(a) >>> sh);
            4'd10: begin r = a * b;                             lat = MC_LAT; end
            4'd11: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b;  lat = MC_LAT; end
            4'd12: begin r = (b == 0) ? a : a % b;              lat = MC_LAT; end
            default: begin r = 32'd0; e = 1'b1; end
        endcase
    endtask

    // Issue one op, measure accept-to-valid edges, check the result, hold it
    // under backpressure for `hold` cycles, then drain it.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e,
                         input int exp_lat, input int hold);
        int w, lat, busy_lo;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_op    = op;
        src1      = a;
        src2      = b;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = $urandom;  // operands must already have been captured
        src2     = $urandom;
        alu_op   = OP_W'($urandom);
        lat      = 0;
        busy_lo  = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy_lo++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/in_ready_low"}, 64'(busy_lo), 64'(exp_lat));
        check({tag, "/valid"}, 64'(out_valid), 64'd1);
        check({tag, "/result"}, 64'(alu_result), 64'(exp_r));
        check({tag, "/err"}, 64'(err), 64'(exp_e));
        check({tag, "/zero"}, 64'(zero), 64'(exp_r == 32'd0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/held_valid"}, 64'(out_valid), 64'd1);
            check({tag, "/held_result"}, 64'(alu_result), 64'(exp_r));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/drained"}, 64'(out_valid), 64'd0);
        check({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        int          el;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          seen_valid, seen_busy;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/in_ready", 64'(in_ready), 64'd1);
        check("reset/result", 64'(alu_result), 64'd0);
        check("reset/zero", 64'(zero), 64'd1);
        check("reset/err", 64'(err), 64'd0);
        rst = 1'b1;

        // Directed single-cycle ops
        do_op("srl",  4'd5, 32'hFFFF_FFF5, 32'h12, 32'h0000_3FFF, 1'b0, 0, 1);
        do_op("sra",  4'd9, 32'hFFFF_FFF5, 32'h12, 32'hFFFF_FFFF, 1'b0, 0, 0);
        do_op("slt",  4'd3, 32'hFFFF_FFFF, 32'h1,  32'd1,         1'b0, 0, 0);
        do_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'h1,  32'd0,         1'b0, 0, 0);

        // Multi-cycle ops
        do_op("mul",   4'd10, 32'h0001_0003, 32'h5, 32'h0005_000F, 1'b0, MC_LAT, 2);
        do_op("divu",  4'd11, 32'd100, 32'd7, 32'd14,          1'b0, MC_LAT, 0);
        do_op("remu",  4'd12, 32'd100, 32'd7, 32'd2,           1'b0, MC_LAT, 0);
        do_op("divu0", 4'd11, 32'd5,   32'd0, 32'hFFFF_FFFF,   1'b0, MC_LAT, 0);
        do_op("remu0", 4'd12, 32'd5,   32'd0, 32'd5,           1'b0, MC_LAT, 0);

        // Backpressure then back-to-back issue
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd1; src1 = 32'd10; src2 = 32'd10; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp/valid", 64'(out_valid), 64'd1);
        check("bp/result", 64'(alu_result), 64'd0);
        check("bp/zero", 64'(zero), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp/held_valid", 64'(out_valid), 64'd1);
            check("bp/held_result", 64'(alu_result), 64'd0);
            check("bp/held_zero", 64'(zero), 64'd1);
            check("bp/in_ready_low", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        check("b2b/in_ready_follows", 64'(in_ready), 64'd0);
        out_ready = 1'b1; in_valid = 1'b1; alu_op = 4'd0; src1 = 32'd30; src2 = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b/valid", 64'(out_valid), 64'd1);
        check("b2b/result", 64'(alu_result), 64'd50);
        check("b2b/zero", 64'(zero), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b/drained", 64'(out_valid), 64'd0);

        // Illegal opcode followed by a legal op
        do_op("illegal", 4'd14, 32'h1234, 32'h5678, 32'd0, 1'b1, 0, 1);
        do_op("and",     4'd7,  32'd1,    32'd1,    32'd1, 1'b0, 0, 0);

        // Reset during BUSY
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd11; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstbusy/out_valid", 64'(out_valid), 64'd0);
        check("rstbusy/in_ready", 64'(in_ready), 64'd1);
        check("rstbusy/result", 64'(alu_result), 64'd0);
        check("rstbusy/zero", 64'(zero), 64'd1);
        check("rstbusy/err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen_valid = 0;
        seen_busy  = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
            if (!in_ready) seen_busy++;
        end
        check("rstbusy/no_valid_after", 64'(seen_valid), 64'd0);
        check("rstbusy/ready_after", 64'(seen_busy), 64'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = a >> $urandom_range(0, 31);
            ref_model(op, a, b, er, ee, el);
            do_op($sformatf("rand%0d_op%0d", n, op), op, a, b, er, ee, el,
                  int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parameterised, handshaked successor to the combinational RV32I ALU. Adds signed/unsigned compare and arithmetic shift, plus iterative unsigned multiply, divide and remainder. Operands are accepted on a valid/ready input channel, and results are returned on a valid/ready output channel together with zero and error flags. The block sits between decode/issue and writeback, so a multi-cycle operation stalls issue through `in_ready` without any external counters.

## Interface
- `DATA_W`, default 32: operand/result width; must be a power of two, ≥8.
- `OP_W`, default 4: opcode width.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand/opcode valid.
- `in_ready` output 1: block can accept an operation.
- `alu_op` input `OP_W`: operation select.
- `src1`, `src2` input `DATA_W`: operands.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `alu_result` output `DATA_W`: registered result.
- `zero` output 1: high when `alu_result == 0`.
- `err` output 1: illegal opcode was accepted.

## Operation
- Opcode encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 XOR, 5 SRL, 6 OR, 7 AND (same values as the previous ALU).
  - 8 SLTU, 9 SRA.
  - 10 MUL: low `DATA_W` bits of the product.
  - 11 DIVU, 12 REMU.
  - 13–15 illegal.
- Arithmetic is modulo 2^`DATA_W`.
- Shifts use only `src2[$clog2(DATA_W)-1:0]`.
- SLT/SLTU return 0 or 1, zero-extended.
- Division by zero: DIVU returns all-ones; REMU returns `src1`. No trap is raised.
- Illegal opcode: `alu_result = 0`, `err = 1`, `zero = 1`.
- A transfer occurs on a rising edge when both `valid` and `ready` of a channel are high. Operands are captured at transfer, so the source may change inputs afterwards.
- FSM states:
  - IDLE: `in_ready = 1`.
    - On input transfer with op 0–9 or 13–15, compute and register the result, then go to DONE.
    - On input transfer with op 10–12, load the mul/div unit and go to BUSY.
  - BUSY: `in_ready = 0`. The iteration counter runs `DATA_W` cycles; when it completes, register the result and go to DONE.
  - DONE: `out_valid = 1`. `alu_result`, `zero` and `err` are held stable until output transfer.
    - `in_ready = out_ready`, so back-to-back issue is possible.
    - Output transfer with no new input: go to IDLE.
    - Output transfer with a simultaneous input transfer: process the new op exactly as from IDLE.
- `out_valid` never drops without an output transfer.
- `err` and `zero` are only meaningful while `out_valid` is high.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, `in_ready = 1`, `out_valid = 0`.
  - `alu_result = 0`, `zero = 1`, `err = 0`, iteration counter 0.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. The result is discarded and no `out_valid` is produced.
- Single-cycle ops: input transfer at edge N, `out_valid` high after edge N. Latency 1.
- MUL/DIVU/REMU: input transfer at edge N, `out_valid` high after edge N+`DATA_W`+1. Latency `DATA_W`+1 (33 at default).
- Throughput:
  - 1 op/cycle for single-cycle ops while `out_ready` is held high.
  - 1 op per `DATA_W`+1 cycles for multi-cycle ops.
- No combinational path from `in_valid` or operands to any output. `in_ready` depends combinationally on `out_ready` in DONE only.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_e` enum with the encodings above;
  - `alu_state_e` (IDLE, BUSY, DONE);
  - a function `alu_is_multicycle(op)`.
- Sub-module `alu_muldiv`:
  - shift-add multiplier and restoring divider sharing one `DATA_W`-bit accumulator and a `$clog2(DATA_W)+1`-bit counter;
  - ports `start`, `op`, `a`, `b`, `busy`, `done`, `result`;
  - resets via the same `rst`.
- Top holds the FSM, the single-cycle datapath and the output registers.

## Test plan (DATA_W=32)
- Single-cycle ops:
  - SRL `src1 = 0xFFFFFFF5`, `src2 = 0x12` → `0x00003FFF`.
  - SRA same operands → `0xFFFFFFFF`.
  - SLT `0xFFFFFFFF`, `0x1` → 1; SLTU same operands → 0.
  - Each with `out_valid` one cycle after accept.
- Multiply: MUL `0x00010003 × 0x00000005` → `0x0005000F`. `in_ready` low for 33 cycles; `out_valid` exactly 33 cycles after accept.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU 5/0 → `0xFFFFFFFF`; REMU 5/0 → 5.
- Backpressure and back-to-back issue: SUB 10−10 with `out_ready` low for 5 cycles → result 0, `zero = 1`, held stable throughout. Raising `out_ready` together with `in_valid` on ADD 30+20 → 50 on the next cycle.
- Illegal opcode: op 14 → `alu_result = 0`, `err = 1`, `zero = 1`. A following AND `1 & 1` → 1, `err = 0`.
- Reset during BUSY: assert `rst` (low) 10 cycles into a DIVU → all outputs return to reset values immediately. After release, no `out_valid` appears and `in_ready = 1`.
